// File: rtl/dt_pkg.sv
// Shared types and constants for the DataTransfer command sequencer.
package dt_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_LOAD_A = 3'd2,
    OP_LOAD_B = 3'd3,
    OP_MOV_AB = 3'd4,
    OP_MOV_BA = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // Opcodes that move data and therefore count as completed transfers.
  function automatic logic op_is_xfer(input logic [OP_W-1:0] op);
    return (op >= OP_W'(OP_WRITE)) && (op <= OP_W'(OP_MOV_BA));
  endfunction

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op > OP_W'(OP_MOV_BA);
  endfunction

endpackage

// File: rtl/dt_ctrl_if.sv
// Command handshake plus DataTransfer control strobes.
interface dt_ctrl_if
  import dt_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_data;
  logic             FR_W;
  logic [AW-1:0]    FR_WADDR;
  logic [DW-1:0]    FR_WDATA;
  logic [AW-1:0]    DataA;
  logic [AW-1:0]    DataB;
  logic             SEL_A;
  logic             SEL_B;
  logic             LD_A;
  logic             LD_B;
  logic             OEA;
  logic             OEB;
  logic             done;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, FR_W, FR_WADDR, FR_WDATA, DataA, DataB, SEL_A, SEL_B,
           LD_A, LD_B, OEA, OEB, done, err, err_sticky, xfer_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, FR_W, FR_WADDR, FR_WDATA, DataA, DataB, SEL_A, SEL_B,
           LD_A, LD_B, OEA, OEB, done, err, err_sticky, xfer_cnt
  );
endinterface

// File: rtl/dt_ctrl.sv
// Sequences one command at a time through SETUP/EXEC and drives registered
// DataTransfer strobes; OEA/OEB are never both high.
module dt_ctrl
  import dt_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input logic       clk,
  input logic       rst,
  dt_ctrl_if.slave  bus
);

  state_e           r_state, w_state_nxt;
  logic [OP_W-1:0]  r_op, w_op_nxt;
  logic [AW-1:0]    r_waddr, w_waddr_nxt, r_da, w_da_nxt, r_db, w_db_nxt;
  logic [DW-1:0]    r_wdata, w_wdata_nxt;
  logic             r_sela, w_sela_nxt, r_selb, w_selb_nxt;
  logic             r_fr_w, w_fr_w_nxt, r_ld_a, w_ld_a_nxt, r_ld_b, w_ld_b_nxt;
  logic             r_oea, w_oea_nxt, r_oeb, w_oeb_nxt;
  logic             r_done, w_done_nxt, r_err, w_err_nxt, r_sticky, w_sticky_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Next state and next registered outputs; SETUP values are computed at accept.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;
    w_da_nxt     = r_da;
    w_db_nxt     = r_db;
    w_sela_nxt   = r_sela;
    w_selb_nxt   = r_selb;
    w_fr_w_nxt   = 1'b0;
    w_ld_a_nxt   = 1'b0;
    w_ld_b_nxt   = 1'b0;
    w_oea_nxt    = 1'b0;
    w_oeb_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_sticky_nxt = r_sticky;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt = ST_SETUP;
          w_op_nxt    = bus.cmd_op;
          case (bus.cmd_op)
            OP_WRITE: begin
              w_waddr_nxt = bus.cmd_addr;
              w_wdata_nxt = bus.cmd_data;
            end
            OP_LOAD_A: begin
              w_da_nxt   = bus.cmd_addr;
              w_sela_nxt = 1'b1;
            end
            OP_LOAD_B: begin
              w_db_nxt   = bus.cmd_addr;
              w_selb_nxt = 1'b1;
            end
            OP_MOV_AB: begin
              w_oea_nxt  = 1'b1;
              w_selb_nxt = 1'b0;
            end
            OP_MOV_BA: begin
              w_oeb_nxt  = 1'b1;
              w_sela_nxt = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_EXEC;
        w_oea_nxt   = r_oea;
        w_oeb_nxt   = r_oeb;
        w_done_nxt  = 1'b1;
        w_err_nxt   = op_is_illegal(r_op);
        case (r_op)
          OP_WRITE:  w_fr_w_nxt = 1'b1;
          OP_LOAD_A: w_ld_a_nxt = 1'b1;
          OP_LOAD_B: w_ld_b_nxt = 1'b1;
          OP_MOV_AB: w_ld_b_nxt = 1'b1;
          OP_MOV_BA: w_ld_a_nxt = 1'b1;
          default: ;
        endcase
      end
      ST_EXEC: begin
        w_state_nxt = ST_IDLE;
        if (op_is_xfer(r_op)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (op_is_illegal(r_op)) begin
          w_sticky_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_da     <= '0;
      r_db     <= '0;
      r_sela   <= 1'b0;
      r_selb   <= 1'b0;
      r_fr_w   <= 1'b0;
      r_ld_a   <= 1'b0;
      r_ld_b   <= 1'b0;
      r_oea    <= 1'b0;
      r_oeb    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_da     <= w_da_nxt;
      r_db     <= w_db_nxt;
      r_sela   <= w_sela_nxt;
      r_selb   <= w_selb_nxt;
      r_fr_w   <= w_fr_w_nxt;
      r_ld_a   <= w_ld_a_nxt;
      r_ld_b   <= w_ld_b_nxt;
      r_oea    <= w_oea_nxt;
      r_oeb    <= w_oeb_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_sticky <= w_sticky_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.FR_W       = r_fr_w;
  assign bus.FR_WADDR   = r_waddr;
  assign bus.FR_WDATA   = r_wdata;
  assign bus.DataA      = r_da;
  assign bus.DataB      = r_db;
  assign bus.SEL_A      = r_sela;
  assign bus.SEL_B      = r_selb;
  assign bus.LD_A       = r_ld_a;
  assign bus.LD_B       = r_ld_b;
  assign bus.OEA        = r_oea;
  assign bus.OEB        = r_oeb;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_sticky;
  assign bus.xfer_cnt   = r_cnt;

endmodule

// File: tb/tb_dt_ctrl.sv
// Bench for dt_ctrl: directed table, reset/stream corners, random commands
// against a per-command model, and counter wrap.
module tb_dt_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dt_ctrl_if bus ();

  dt_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0] op;
    logic [4:0] addr;
    logic [7:0] data;
    logic [5:0] exp_strb;   // {FR_W, LD_A, LD_B, OEA, OEB, err} in EXEC
    logic [7:0] exp_cnt;
    logic       exp_sticky;
  } vec_t;

  vec_t vt [9];

  // Architectural state the model tracks across commands.
  logic [4:0] m_waddr, m_da, m_db;
  logic [7:0] m_wdata;
  logic       m_sela, m_selb, m_sticky;
  int         m_cnt;

  function automatic logic [41:0] pack(
    input logic rdy, input logic fw, input logic [4:0] wa, input logic [7:0] wd,
    input logic [4:0] da, input logic [4:0] db, input logic sa, input logic sb,
    input logic la, input logic lb, input logic oa, input logic ob,
    input logic dn, input logic er, input logic st, input logic [7:0] cnt);
    return {rdy, fw, wa, wd, da, db, sa, sb, la, lb, oa, ob, dn, er, st, cnt};
  endfunction

  function automatic logic [41:0] got_vec();
    return pack(bus.cmd_ready, bus.FR_W, bus.FR_WADDR, bus.FR_WDATA, bus.DataA,
                bus.DataB, bus.SEL_A, bus.SEL_B, bus.LD_A, bus.LD_B, bus.OEA,
                bus.OEB, bus.done, bus.err, bus.err_sticky, bus.xfer_cnt);
  endfunction

  function automatic logic [41:0] zero_vec();
    return pack(1'b1, 1'b0, 5'd0, 8'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endfunction

  task automatic check(input string name, input logic [41:0] got, input logic [41:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_waddr = '0; m_wdata = '0; m_da = '0; m_db = '0;
    m_sela = 1'b0; m_selb = 1'b0; m_sticky = 1'b0; m_cnt = 0;
  endtask

  // Reset with a command offered during rst, which must not be accepted.
  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_addr = 5'd7; bus.cmd_data = 8'h3C;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    model_clear();
    check("reset", got_vec(), zero_vec());
    @(posedge clk); #1;
    check("reset_idle", got_vec(), zero_vec());
  endtask

  // Issue one command from IDLE and check SETUP, EXEC and the following IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] addr,
                         input logic [7:0] data, output logic [5:0] strb);
    logic legal, ill;
    legal = (op >= 3'd1) && (op <= 3'd5);
    ill   = (op >= 3'd6);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
    @(posedge clk); #1;
    // Junk offered while busy must be ignored.
    bus.cmd_op = 3'($urandom); bus.cmd_addr = 5'($urandom); bus.cmd_data = 8'($urandom);
    case (op)
      3'd1: begin m_waddr = addr; m_wdata = data; end
      3'd2: begin m_da = addr; m_sela = 1'b1; end
      3'd3: begin m_db = addr; m_selb = 1'b1; end
      3'd4: m_selb = 1'b0;
      3'd5: m_sela = 1'b0;
      default: ;
    endcase
    check("setup", got_vec(),
          pack(1'b0, 1'b0, m_waddr, m_wdata, m_da, m_db, m_sela, m_selb, 1'b0, 1'b0,
               op == 3'd4, op == 3'd5, 1'b0, 1'b0, m_sticky, 8'(m_cnt % 256)));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("exec", got_vec(),
          pack(1'b0, op == 3'd1, m_waddr, m_wdata, m_da, m_db, m_sela, m_selb,
               (op == 3'd2) || (op == 3'd5), (op == 3'd3) || (op == 3'd4),
               op == 3'd4, op == 3'd5, 1'b1, ill, m_sticky, 8'(m_cnt % 256)));
    strb = {bus.FR_W, bus.LD_A, bus.LD_B, bus.OEA, bus.OEB, bus.err};
    @(posedge clk); #1;
    if (legal) m_cnt = m_cnt + 1;
    if (ill) m_sticky = 1'b1;
    check("idle", got_vec(),
          pack(1'b1, 1'b0, m_waddr, m_wdata, m_da, m_db, m_sela, m_selb, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, m_sticky, 8'(m_cnt % 256)));
  endtask

  initial begin
    logic [5:0] strb;
    logic [2:0] sops [4];
    int acc [$];
    int k;

    vt[0] = '{3'd1, 5'd5,  8'hA5, 6'b100000, 8'd1, 1'b0};
    vt[1] = '{3'd2, 5'd3,  8'h00, 6'b010000, 8'd2, 1'b0};
    vt[2] = '{3'd4, 5'd0,  8'h00, 6'b001100, 8'd3, 1'b0};
    vt[3] = '{3'd3, 5'd9,  8'h11, 6'b001000, 8'd4, 1'b0};
    vt[4] = '{3'd5, 5'd1,  8'h22, 6'b010010, 8'd5, 1'b0};
    vt[5] = '{3'd0, 5'd4,  8'h33, 6'b000000, 8'd5, 1'b0};
    vt[6] = '{3'd7, 5'd6,  8'h44, 6'b000001, 8'd5, 1'b1};
    vt[7] = '{3'd6, 5'd2,  8'h55, 6'b000001, 8'd5, 1'b1};
    vt[8] = '{3'd1, 5'd31, 8'hFF, 6'b100000, 8'd6, 1'b1};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;

    // Directed table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_cmd(vt[i].op, vt[i].addr, vt[i].data, strb);
      check($sformatf("tbl_strb[%0d]", i), 42'(strb), 42'(vt[i].exp_strb));
      check($sformatf("tbl_cnt[%0d]", i), 42'(bus.xfer_cnt), 42'(vt[i].exp_cnt));
      check($sformatf("tbl_sticky[%0d]", i), 42'(bus.err_sticky), 42'(vt[i].exp_sticky));
    end

    // Reset during the SETUP of a MOV_BA discards it
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5; bus.cmd_addr = 5'd12;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("mid_setup_oe", 42'({bus.OEA, bus.OEB}), 42'(2'b01));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst", got_vec(), zero_vec());
    @(posedge clk); #1;
    check("mid_nodone", got_vec(), zero_vec());

    // cmd_valid held high across a stream of four commands
    do_reset();
    sops[0] = 3'd4; sops[1] = 3'd5; sops[2] = 3'd4; sops[3] = 3'd2;
    k = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = sops[0]; bus.cmd_addr = 5'd8;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      if (bus.cmd_ready) begin
        acc.push_back(cyc);
        k++;
      end
      @(posedge clk); #1;
      if (k < 4) bus.cmd_op = sops[k];
      check("oe_excl", 42'(bus.OEA & bus.OEB), 42'(0));
    end
    bus.cmd_valid = 1'b0;
    check("stream_accepts", 42'(acc.size()), 42'(4));
    for (int i = 1; i < acc.size(); i++)
      check($sformatf("stream_gap[%0d]", i), 42'(acc[i] - acc[i-1]), 42'(3));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("oe_excl_tail", 42'(bus.OEA & bus.OEB), 42'(0));
    end
    check("stream_cnt", 42'(bus.xfer_cnt), 42'(4));

    // Random commands against the model
    do_reset();
    for (int i = 0; i < 150; i++)
      run_cmd(3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom), strb);

    // xfer_cnt wraps after 256 legal commands
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_cmd(3'd1, 5'($urandom), 8'($urandom), strb);
      if (i == 254) check("wrap_255", 42'(bus.xfer_cnt), 42'(255));
    end
    check("wrap_0", 42'(bus.xfer_cnt), 42'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dt_ctrl.md
# dt_ctrl

Command sequencer directly upstream of the DataTransfer datapath. It accepts one transfer command at a time over a valid/ready handshake and generates the cycle-accurate control strobes that DataTransfer consumes:
- file-register write port,
- read addresses,
- A/B mux selects, register loads and bus output enables.

It guarantees that OEA and OEB are never asserted together, so the shared ABus never has two drivers.

## Interface
Parameters:
- AW, 5, file-register address width (FR_WADDR, DataA, DataB, cmd_addr)
- DW, 8, file-register data width (FR_WDATA, cmd_data)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high iff state is IDLE
- cmd_op  in  3  opcode: 0 NOP, 1 WRITE, 2 LOAD_A, 3 LOAD_B, 4 MOV_AB, 5 MOV_BA, 6–7 illegal
- cmd_addr  in  AW  file-register address for WRITE/LOAD_A/LOAD_B
- cmd_data  in  DW  write data for WRITE
- FR_W  out  1  file-register write strobe
- FR_WADDR  out  AW  file-register write address
- FR_WDATA  out  DW  file-register write data
- DataA, DataB  out  AW  file-register read addresses, ports 1/2
- SEL_A, SEL_B  out  1  mux select: 1 = file-register read data (QA/QB), 0 = ABus
- LD_A, LD_B  out  1  register A/B load strobe
- OEA, OEB  out  1  tristate enable of register A/B onto ABus
- done  out  1  one-cycle pulse in the EXEC cycle of every accepted command
- err  out  1  one-cycle pulse in EXEC for an illegal opcode
- err_sticky  out  1  set by any illegal opcode; cleared only by rst
- xfer_cnt  out  8  count of completed legal non-NOP commands; wraps 255→0

## Operation
States: IDLE → SETUP → EXEC → IDLE.

Command acceptance and sequencing:
- A command is accepted when cmd_valid & cmd_ready are both high at a clock edge. cmd_op, cmd_addr and cmd_data are latched at that edge.
- Command inputs are ignored outside IDLE.
- Every command, including NOP and illegal opcodes, takes exactly SETUP then EXEC.

Per-op control behaviour (SETUP values are held through EXEC):
- WRITE: FR_WADDR=addr and FR_WDATA=data from SETUP; FR_W=1 in EXEC only.
- LOAD_A: DataA=addr and SEL_A=1 from SETUP; LD_A=1 in EXEC.
- LOAD_B: same as LOAD_A with DataB, SEL_B and LD_B.
- MOV_AB: OEA=1 and SEL_B=0 from SETUP; LD_B=1 in EXEC; OEA drops in the cycle after EXEC.
- MOV_BA: same as MOV_AB with the A/B roles swapped.
- NOP: no strobes; done pulses in EXEC; xfer_cnt unchanged.
- Illegal opcode (6–7): no strobes; done and err pulse in EXEC; err_sticky set; xfer_cnt unchanged.

Output hold rules:
- FR_WADDR, FR_WDATA, DataA, DataB and SEL_A/B hold their last driven value when not in use.
- FR_W, LD_A/B and OEA/B are 0 whenever they are not explicitly asserted above.

Invariant: OEA & OEB == 0 in every cycle.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the state register.
- Accept at edge N: SETUP during cycle N+1, EXEC during N+2, back in IDLE (cmd_ready=1) during N+3.
- Throughput is one command per 3 cycles.
- xfer_cnt and err_sticky update on the edge that ends EXEC.
- Reset values: state IDLE; every output 0 (including FR_WADDR, FR_WDATA, DataA, DataB, SEL_A/B, xfer_cnt, err_sticky); cmd_ready=1 once rst is low.
- Reset mid-operation: at the next edge the state returns to IDLE, all strobes and OEs drop to 0, and the in-flight command is discarded with no done pulse.
- A cmd_valid presented while rst is high is not accepted.
- cmd_valid held high continuously: consecutive commands are accepted on each IDLE cycle.
- Back-to-back MOV_AB then MOV_BA: OEA and OEB are never high in the same cycle; the IDLE cycle between commands separates them.

## Structure
- Package dt_pkg holds:
  - op_e enum (NOP, WRITE, LOAD_A, LOAD_B, MOV_AB, MOV_BA);
  - state_e enum (IDLE, SETUP, EXEC);
  - AW/DW default constants.
- Single module dt_ctrl; no sub-module required.
- Top-level integration connects dt_ctrl outputs 1:1 to the same-named DataTransfer inputs.

## Test plan
- Reset, then WRITE addr=5 data=0xA5 accepted at edge N: FR_WADDR=5 and FR_WDATA=0xA5 in cycles N+1 and N+2; FR_W=1 only in N+2; done=1 in N+2; xfer_cnt=1.
- LOAD_A addr=3 then MOV_AB: DataA=3 and SEL_A=1 with LD_A at +2; then OEA=1 for two cycles with SEL_B=0 and LD_B in the second; OEB stays 0 throughout.
- cmd_valid held high with a stream of 4 commands: accepts spaced exactly 3 cycles; cmd_ready low in SETUP/EXEC; OEA&OEB never 1 (assertion).
- Opcode 7: err and done pulse in EXEC; no strobes; err_sticky=1 until rst; xfer_cnt unchanged. NOP: done only.
- rst asserted during the SETUP of a MOV_BA: next cycle all outputs 0, no done, cmd_ready=1 after rst falls.
- 256 legal WRITEs: xfer_cnt wraps from 255 to 0.
